// File: rtl/alu_pkg.sv
// Shared op indices, FSM encoding and default latency
// for the ALU sequencer.
package alu_pkg;

   localparam int LAT_DEF = 3;

   localparam logic [3:0] OP_SUM  = 4'd0;
   localparam logic [3:0] OP_DIFF = 4'd1;
   localparam logic [3:0] OP_NOT  = 4'd2;
   localparam logic [3:0] OP_NAND = 4'd3;
   localparam logic [3:0] OP_NOR  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_OR   = 4'd7;
   localparam logic [3:0] OP_XNOR = 4'd8;
   localparam logic [3:0] OP_LAST = OP_XNOR;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_CAPTURE = 2'd3;

endpackage

// File: rtl/alu_op_decode.sv
// Binary op index to one-hot ALU select;
// out-of-range indices select nothing.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [3:0]  idx,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (idx <= OP_LAST) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/alu_sequencer.sv
// Issues single ops or a full nine-op sweep to an external
// fixed-latency ALU and captures its results.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int LAT = LAT_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        sweep,
   input  logic [3:0]  op_sel,
   input  logic [7:0]  a_in,
   input  logic [7:0]  b_in,
   input  logic        alu_neg,
   input  logic [3:0]  alu_r1,
   input  logic [3:0]  alu_r2,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [15:0] alu_op,
   output logic        busy,
   output logic        done,
   output logic [7:0]  result,
   output logic        neg,
   output logic        last,
   output logic        err
);

   localparam int CW     = $clog2(LAT) + 1;
   localparam int WAIT_N = (LAT > 1) ? LAT - 2 : 0;

   logic [1:0]    state;
   logic [3:0]    idx;
   logic [3:0]    nxt_idx;
   logic          sweep_q;
   logic          bad_q;
   logic          bad_sel;
   logic [CW-1:0] cnt;
   logic [15:0]   dec_op;

   assign busy    = (state != S_IDLE);
   assign bad_sel = !sweep && (op_sel > OP_LAST);

   // One decoder serves both the first issue and sweep advances
   always_comb begin
      nxt_idx = idx + 4'd1;
      if (state == S_IDLE) nxt_idx = sweep ? OP_SUM : op_sel;
   end

   alu_op_decode u_dec (
      .idx    (nxt_idx),
      .onehot (dec_op)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         idx     <= '0;
         sweep_q <= 1'b0;
         bad_q   <= 1'b0;
         cnt     <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_op  <= '0;
         done    <= 1'b0;
         result  <= '0;
         neg     <= 1'b0;
         last    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         last <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  alu_a   <= a_in;
                  alu_b   <= b_in;
                  sweep_q <= sweep;
                  bad_q   <= bad_sel;
                  idx     <= bad_sel ? OP_SUM : nxt_idx;
                  alu_op  <= dec_op;
                  state   <= bad_sel ? S_CAPTURE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt <= CW'(WAIT_N);
               if (LAT > 1) state <= S_WAIT;
               else         state <= S_CAPTURE;
            end
            S_WAIT: begin
               if (cnt == '0) state <= S_CAPTURE;
               else           cnt   <= cnt - 1'b1;
            end
            S_CAPTURE: begin
               done   <= 1'b1;
               err    <= bad_q;
               result <= bad_q ? 8'h00 : {alu_r1, alu_r2};
               neg    <= bad_q ? 1'b0 : alu_neg;
               if (sweep_q && idx != OP_LAST) begin
                  idx    <= nxt_idx;
                  alu_op <= dec_op;
                  state  <= S_ISSUE;
               end else begin
                  last   <= 1'b1;
                  alu_op <= '0;
                  bad_q  <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
